// File: rtl/instr_mem_responder.sv
// Multi-cycle instruction-memory responder for the stalling fetch pipeline.
// One request in flight at a time; the response arrives LATENCY cycles later.
module instr_mem_responder #(
    parameter int LATENCY        = 4,
    parameter int MEM_WORDS_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    input  logic        req_wr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        stall
);

    localparam int DEPTH = 1 << MEM_WORDS_LOG2;
    localparam logic [3:0] CNT_INIT =
        (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                    state;
    logic [3:0]                cnt;
    logic [MEM_WORDS_LOG2-1:0] cap_idx;
    logic                      cap_mis;
    logic                      cap_wr;
    logic [15:0]               cap_wdata;
    logic [15:0]               mem [DEPTH];
    logic                      unused_addr;

    // High address bits only alias; fold them so they are visibly consumed.
    assign unused_addr = ^req_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            stall     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            cap_idx   <= '0;
            cap_mis   <= 1'b0;
            cap_wr    <= 1'b0;
            cap_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_idx   <= req_addr[MEM_WORDS_LOG2:1];
                        cap_mis   <= req_addr[0];
                        cap_wr    <= req_wr;
                        cap_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        stall     <= 1'b1;
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= req_addr[0];
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= cap_mis;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    stall     <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rsp_data = (state == RESP && !cap_wr && !cap_mis)
                    ? mem[cap_idx] : '0;

    // Storage is not reset; a reset landing in RESP still drops the write.
    always_ff @(posedge clk) begin
        if (rst_n && state == RESP && cap_wr && !cap_mis) begin
            mem[cap_idx] <= cap_wdata;
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder; LATENCY 4 and LATENCY 1
// instances share one random request stream with per-instance models.
module tb_instr_mem_responder;

    localparam int L0 = 4;
    localparam int L1 = 1;

    typedef struct {
        logic [15:0] data;
        logic        err;
        bit          chk;
        bit          wr;
        int          idx;
        logic [15:0] wdata;
        int          due;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            req_valid = 1'b0;
    logic [15:0]     req_addr = '0;
    logic            req_wr = 1'b0;
    logic [15:0]     req_wdata = '0;
    logic [1:0]      rdy;
    logic [1:0]      rv;
    logic [1:0]      re;
    logic [1:0]      st;
    logic [1:0][15:0] rd;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          last_acc [2] = '{-100, -100};
    logic [15:0] ref_mem [2][256];
    bit          known [2][256];
    exp_t        q0 [$];
    exp_t        q1 [$];

    instr_mem_responder #(.LATENCY(L0), .MEM_WORDS_LOG2(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_addr(req_addr), .req_wr(req_wr), .req_wdata(req_wdata),
        .req_ready(rdy[0]), .rsp_valid(rv[0]), .rsp_data(rd[0]),
        .rsp_err(re[0]), .stall(st[0])
    );

    instr_mem_responder #(.LATENCY(L1), .MEM_WORDS_LOG2(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_addr(req_addr), .req_wr(req_wr), .req_wdata(req_wdata),
        .req_ready(rdy[1]), .rsp_valid(rv[1]), .rsp_data(rd[1]),
        .rsp_err(re[1]), .stall(st[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int id);
        return (id == 0) ? L0 : L1;
    endfunction

    function automatic bit model_ready(input int id);
        return !(cyc > last_acc[id] && cyc <= last_acc[id] + lat(id));
    endfunction

    function automatic int qsize(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int qdue(input int id);
        return (id == 0) ? q0[0].due : q1[0].due;
    endfunction

    task automatic qpush(input int id, input exp_t e);
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic qpop(input int id, output exp_t e);
        if (id == 0) e = q0.pop_front();
        else e = q1.pop_front();
    endtask

    task automatic cmp(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d actual %0h required %0h",
                     name, id, cyc, act, exp);
        end
    endtask

    task automatic accept(input int id, input logic [15:0] a,
                          input logic w, input logic [15:0] d);
        exp_t e;
        last_acc[id] = cyc;
        e.due   = cyc + lat(id);
        e.idx   = (int'(a) / 2) % 256;
        e.wdata = d;
        e.wr    = 1'b0;
        e.chk   = 1'b1;
        e.err   = 1'b0;
        e.data  = '0;
        if (a % 2 == 1) begin
            e.err = 1'b1;
        end else if (w) begin
            e.wr = 1'b1;
        end else begin
            e.data = ref_mem[id][e.idx];
            e.chk  = known[id][e.idx];
        end
        qpush(id, e);
    endtask

    task automatic apply(input int id, input exp_t e);
        if (e.wr) begin
            ref_mem[id][e.idx] = e.wdata;
            known[id][e.idx]   = 1'b1;
        end
    endtask

    task automatic mon(input int id);
        exp_t e;
        bit   busy;
        busy = !model_ready(id);
        cmp("stall", id, st[id], busy);
        cmp("req_ready", id, rdy[id], !busy);
        if (rv[id]) begin
            if (qsize(id) == 0) begin
                cmp("unexpected_rsp", id, rv[id], 0);
            end else begin
                qpop(id, e);
                cmp("rsp_cycle", id, cyc, e.due);
                cmp("rsp_err", id, re[id], e.err);
                if (e.chk) cmp("rsp_data", id, rd[id], e.data);
                apply(id, e);
            end
        end else begin
            cmp("idle_data", id, rd[id], 0);
            if (qsize(id) != 0 && qdue(id) < cyc) begin
                qpop(id, e);
                cmp("rsp_missing", id, rv[id], 1);
                apply(id, e);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic drive(input logic v, input logic [15:0] a,
                         input logic w, input logic [15:0] d);
        @(negedge clk);
        #1;
        req_valid = v;
        req_addr  = a;
        req_wr    = w;
        req_wdata = d;
        if (v) begin
            for (int id = 0; id < 2; id++) begin
                if (model_ready(id)) accept(id, a, w, d);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(model_ready(0) && model_ready(1)
                 && q0.size() == 0 && q1.size() == 0)) begin
            if (n == 50) begin
                cmp("idle_timeout", 0, q0.size() + q1.size(), 0);
                q0.delete();
                q1.delete();
                break;
            end
            drive(1'b0, 16'($urandom), 1'($urandom), 16'($urandom));
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int id = 0; id < 2; id++) begin
            cmp({tag, "_rsp_valid"}, id, rv[id], 0);
            cmp({tag, "_rsp_err"}, id, re[id], 0);
            cmp({tag, "_rsp_data"}, id, rd[id], 0);
            cmp({tag, "_stall"}, id, st[id], 0);
            cmp({tag, "_req_ready"}, id, rdy[id], 1);
        end
    endtask

    initial begin
        logic [15:0] a;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        #1 rst_n = 1'b1;

        drive(1'b1, 16'h0010, 1'b1, 16'hBEEF);
        wait_idle();
        drive(1'b1, 16'h0010, 1'b0, 16'h0000);
        wait_idle();
        drive(1'b1, 16'h0011, 1'b1, 16'h1234);
        wait_idle();
        drive(1'b1, 16'h0010, 1'b0, 16'h0000);
        wait_idle();
        drive(1'b1, 16'h0202, 1'b1, 16'hA5A5);
        wait_idle();
        drive(1'b1, 16'h0002, 1'b0, 16'h0000);
        wait_idle();

        drive(1'b1, 16'h0000, 1'b1, 16'h1357);
        wait_idle();
        drive(1'b1, 16'h0002, 1'b1, 16'h2468);
        wait_idle();
        drive(1'b1, 16'h0000, 1'b0, 16'h0000);
        drive(1'b1, 16'h0002, 1'b0, 16'h0000);
        drive(1'b1, 16'h0002, 1'b0, 16'h0000);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000);
        wait_idle();

        drive(1'b1, 16'h0020, 1'b1, 16'h1111);
        wait_idle();
        drive(1'b1, 16'h0020, 1'b1, 16'h7777);
        drive(1'b0, 16'h0040, 1'b1, 16'h4444);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        last_acc[0] = -100;
        last_acc[1] = -100;
        #1 check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 16'h0020, 1'b0, 16'h0000);
        wait_idle();

        for (int i = 0; i < 400; i++) begin
            a = 16'($urandom) & 16'h021F;
            if ($urandom_range(0, 7) == 0) a = 16'($urandom);
            drive(1'($urandom_range(0, 3) != 0), a,
                  1'($urandom), 16'($urandom));
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d actual running required finished",
                 cyc);
        $fatal(1);
    end

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Responder side of the fetch-stage instruction-memory interface. It accepts one word read or write request at a time from the fetch stage and returns a response after a fixed, parameterised latency. It holds `stall` while a request is in flight so the fetch stage freezes its PC. It replaces the single-cycle instruction memory with a multi-cycle model for the stalling-memory pipeline.

## Interface
- `LATENCY`, 4: cycles from request acceptance to the response cycle; legal range 1..15.
- `MEM_WORDS_LOG2`, 8: log2 of storage depth in 16-bit words; the word index is `req_addr[MEM_WORDS_LOG2:1]`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present this cycle.
- `req_addr`  in  16  byte address.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_wdata`  in  16  write data.
- `req_ready`  out  1  responder can accept a request this cycle.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_data`  out  16  read data; 0 whenever `rsp_valid` = 0, and 0 for writes and errors.
- `rsp_err`  out  1  misaligned access; valid only with `rsp_valid`.
- `stall`  out  1  a request is in flight; the fetch stage holds its PC.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `req_ready` = 1. On `req_valid`, capture `req_addr`, `req_wr` and `req_wdata`.
    - If `LATENCY` = 1, go to RESP.
    - Otherwise go to WAIT and load the down-counter with `LATENCY`-2.
  - WAIT: decrement the counter each cycle; go to RESP when it reads 0. Ignore `req_valid`.
  - RESP: assert `rsp_valid`, then always return to IDLE.
- Accept condition: `req_valid` & `req_ready`. Input changes after acceptance have no effect.
- Misaligned access (captured `addr[0]` = 1):
  - `rsp_err` = 1 and `rsp_data` = 0.
  - A write is suppressed; memory is unchanged.
- Address bits above `MEM_WORDS_LOG2` are ignored, so addresses alias (wrap) modulo 2^(`MEM_WORDS_LOG2`+1) bytes. Aliasing is not an error.
- Read: `rsp_data` = mem[index], sampled during the RESP cycle.
- Write: mem[index] is updated at the clock edge ending the RESP cycle. `rsp_data` = 0 and `rsp_err` = 0.
- A read that follows a write to the same index returns the new data.
- `stall` = (state != IDLE).
- `req_ready` = (state == IDLE).

## Timing
- Reset (`rst_n` low, asynchronous):
  - State goes to IDLE and the counter to 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0, `stall` = 0, `req_ready` = 1 after reset.
- Memory contents are not reset.
- Request accepted in cycle T: `stall` = 1 and `req_ready` = 0 in cycles T+1..T+LATENCY; `rsp_valid` = 1 in cycle T+LATENCY only.
- Cycle T+LATENCY+1 is IDLE: `req_ready` = 1 and `stall` = 0. Peak throughput is one request per `LATENCY`+1 cycles.
- All outputs are registered state or decodes of state and registered data. There is no combinational path from `req_*` to any output.
- Reset asserted mid-request:
  - The request is aborted and no response is produced.
  - A pending write is discarded; the write never occurs if reset lands in or before RESP.
- `req_valid` held high through a response: the next request is accepted in cycle T+LATENCY+1, with no duplicate acceptance during WAIT or RESP.

## Test plan
- Reset, then with `LATENCY` = 4 write 0xBEEF to addr 0x0010 at T=0:
  - `stall` = 1 in cycles 1..4; `rsp_valid` in cycle 4 with data 0 and err 0.
  - A read of 0x0010 accepted at T=5 gives `rsp_valid` in cycle 9 with data 0xBEEF.
- Misaligned write to 0x0011 with data 0x1234:
  - `rsp_err` = 1 and `rsp_data` = 0.
  - A following read of 0x0010 still returns 0xBEEF.
- Aliasing with `MEM_WORDS_LOG2` = 8: write 0xA5A5 to 0x0202, then read 0x0002 -> 0xA5A5, err 0.
- `LATENCY` = 1 with `req_valid` held high for reads of 0x0000 and 0x0002 (presented back-to-back): responses in cycles 1 and 3; `req_ready` pattern 1,0,1,0.
- Drop `rst_n` in cycle 2 of a `LATENCY` = 4 write of 0x7777 to 0x0020:
  - No `rsp_valid` appears; outputs go to reset values immediately.
  - A later read of 0x0020 returns the prior contents, not 0x7777.
- Change `req_addr` and `req_wdata` during WAIT: the response reflects only the values captured at acceptance.
